// File: rtl/shaft_cabin_model.sv
// Cabin/shaft plant model: integrates cabin position from the motor command and decodes floor sensors.
// Latency: command sampled at E0 moves pos at E(ACCEL_CYCLES+1); there is no backpressure (free-running plant).
module shaft_cabin_model #(
  parameter int N_FLOORS        = 5,
  parameter int TICKS_PER_FLOOR = 20,
  parameter int SENSOR_HALF_W   = 2,
  parameter int ACCEL_CYCLES    = 3,
  parameter int START_FLOOR     = 1,
  localparam int PW = $clog2((N_FLOORS-1)*TICKS_PER_FLOOR+1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          motor_cmd,
  input  logic [N_FLOORS-1:0] door_open,
  output logic [N_FLOORS-1:0] sensor,
  output logic [3:0]          floor_num,
  output logic [PW-1:0]       pos,
  output logic                moving,
  output logic [1:0]          dir,
  output logic                door_move_err,
  output logic                overtravel_err,
  output logic                invalid_cmd
);

  localparam int CW = (ACCEL_CYCLES > 1) ? $clog2(ACCEL_CYCLES+1) : 1;
  localparam logic [PW-1:0] MAX_POS  = PW'((N_FLOORS-1)*TICKS_PER_FLOOR);
  localparam logic [PW-1:0] RST_POS  = PW'((START_FLOOR-1)*TICKS_PER_FLOOR);
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCEL_CYCLES);

  typedef enum logic [1:0] {ST_STOPPED, ST_STARTING, ST_MOVING_UP, ST_MOVING_DOWN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_q, up_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          dme_q, dme_d, ote_q, ote_d, inv_q, inv_d;
  logic          cmd_up, cmd_dn, door_any;

  assign cmd_up   = (motor_cmd == 2'b01);
  assign cmd_dn   = (motor_cmd == 2'b11);
  assign door_any = |door_open;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOPPED;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      pos_q   <= RST_POS;
      dme_q   <= 1'b0;
      ote_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      pos_q   <= pos_d;
      dme_q   <= dme_d;
      ote_q   <= ote_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    pos_d   = pos_q;
    dme_d   = dme_q;
    ote_d   = ote_q;
    inv_d   = inv_q;
    if (motor_cmd == 2'b10) inv_d = 1'b1;
    case (state_q)
      ST_STOPPED: begin
        if (cmd_up || cmd_dn) begin
          if (door_any) begin
            dme_d = 1'b1;
          end else if ((cmd_up && pos_q == MAX_POS) || (cmd_dn && pos_q == '0)) begin
            ote_d = 1'b1;
          end else begin
            up_d = cmd_up;
            if (ACCEL_CYCLES == 0) begin
              state_d = cmd_up ? ST_MOVING_UP : ST_MOVING_DOWN;
            end else begin
              state_d = ST_STARTING;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end
      ST_STARTING: begin
        // Door, stop and reversal all abort the acceleration phase before the counter is consulted.
        if (door_any) begin
          state_d = ST_STOPPED;
          dme_d   = 1'b1;
        end else if (!(up_q ? cmd_up : cmd_dn)) begin
          state_d = ST_STOPPED;
        end else if (cnt_q == CW'(1)) begin
          state_d = up_q ? ST_MOVING_UP : ST_MOVING_DOWN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_MOVING_UP: begin
        if (door_any) begin
          state_d = ST_STOPPED;
          dme_d   = 1'b1;
        end else if (!cmd_up) begin
          state_d = ST_STOPPED;
        end else if (pos_q == MAX_POS) begin
          state_d = ST_STOPPED;
          ote_d   = 1'b1;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end
      ST_MOVING_DOWN: begin
        if (door_any) begin
          state_d = ST_STOPPED;
          dme_d   = 1'b1;
        end else if (!cmd_dn) begin
          state_d = ST_STOPPED;
        end else if (pos_q == '0) begin
          state_d = ST_STOPPED;
          ote_d   = 1'b1;
        end else begin
          pos_d = pos_q - PW'(1);
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Sensors decode the registered position only, so they never glitch on input changes.
  always_comb begin
    int p;
    p         = int'(pos_q);
    sensor    = '0;
    floor_num = '0;
    for (int k = 0; k < N_FLOORS; k++) begin
      if ((p + SENSOR_HALF_W >= k*TICKS_PER_FLOOR) && (p <= k*TICKS_PER_FLOOR + SENSOR_HALF_W)) begin
        sensor[k] = 1'b1;
        floor_num = 4'(k+1);
      end
    end
  end

  assign pos            = pos_q;
  assign moving         = (state_q == ST_MOVING_UP) || (state_q == ST_MOVING_DOWN);
  assign dir            = (state_q == ST_MOVING_UP) ? 2'b01 : (state_q == ST_MOVING_DOWN) ? 2'b11 : 2'b00;
  assign door_move_err  = dme_q;
  assign overtravel_err = ote_q;
  assign invalid_cmd    = inv_q;

endmodule

// File: tb/tb_shaft_cabin_model.sv
// Directed bench for shaft_cabin_model: expectations queued per edge, compared after each rising edge.
module tb_shaft_cabin_model;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] motor_cmd = 2'b00;
  logic [4:0] door_open = 5'b00000;
  logic [4:0] sensor;
  logic [3:0] floor_num;
  logic [6:0] pos;
  logic       moving;
  logic [1:0] dir;
  logic       door_move_err, overtravel_err, invalid_cmd;

  shaft_cabin_model dut (
    .clock(clock), .reset(reset), .motor_cmd(motor_cmd), .door_open(door_open),
    .sensor(sensor), .floor_num(floor_num), .pos(pos), .moving(moving), .dir(dir),
    .door_move_err(door_move_err), .overtravel_err(overtravel_err), .invalid_cmd(invalid_cmd)
  );

  always #5 clock = ~clock;

  typedef struct {int at; string tag; int sel; int val;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return 32'(pos);
      1: return 32'(sensor);
      2: return 32'(floor_num);
      3: return 32'(moving);
      4: return 32'(dir);
      5: return 32'(door_move_err);
      6: return 32'(overtravel_err);
      7: return 32'(invalid_cmd);
      default: return '1;
    endcase
  endfunction

  // Keep the scoreboard ordered by target edge so draining stops at the first future entry.
  task automatic push(int off, string tag, int sel, int val);
    exp_t e;
    int i;
    e.at = cyc + off; e.tag = tag; e.sel = sel; e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].at <= e.at) i++;
    sb.insert(i, e);
  endtask

  task automatic expect_pos(int off, string tag, int p, int m, int d);
    push(off, tag, 0, p);
    push(off, tag, 3, m);
    push(off, tag, 4, d);
  endtask

  task automatic expect_all(int off, string tag, int p, int s, int f, int m, int d,
                            int de, int oe, int ie);
    expect_pos(off, tag, p, m, d);
    push(off, tag, 1, s);
    push(off, tag, 2, f);
    push(off, tag, 5, de);
    push(off, tag, 6, oe);
    push(off, tag, 7, ie);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      tests++;
      assert (obs(e.sel) === 32'(e.val))
      else begin
        fails++;
        $error("FAIL %s sel%0d: observed %0d expected %0d", e.tag, e.sel, obs(e.sel), e.val);
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      drain();
    end
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge arrives.
  task automatic do_reset(string tag);
    motor_cmd = 2'b00;
    door_open = 5'b00000;
    reset = 1'b0;
    #2;
    expect_all(0, tag, 0, 1, 1, 0, 0, 0, 0, 0);
    drain();
    reset = 1'b1;
  endtask

  initial begin
    #12;
    expect_all(0, "reset", 0, 1, 1, 0, 0, 0, 0, 0);
    drain();
    reset = 1'b1;

    // Start up from floor 1 and reach floor 2.
    motor_cmd = 2'b01;
    expect_pos(3, "accel_e2", 0, 0, 0);
    expect_pos(4, "moving_e3", 0, 1, 1);
    expect_pos(5, "first_step", 1, 1, 1);
    expect_all(7, "leave_f1", 3, 0, 0, 1, 1, 0, 0, 0);
    push(22, "near_f2_pos", 0, 18);
    push(22, "near_f2_sens", 1, 2);
    push(22, "near_f2_fn", 2, 2);
    push(24, "at_f2", 0, 20);
    run(24);

    // Ride to the top and push through it.
    push(60, "top_pos", 0, 80);
    push(60, "top_sens", 1, 16);
    push(60, "top_fn", 2, 5);
    expect_all(61, "top_over", 80, 16, 5, 0, 0, 0, 1, 0);
    run(61);
    expect_pos(1, "top_hold", 80, 0, 0);
    run(1);
    motor_cmd = 2'b11;
    expect_pos(4, "down_go", 80, 1, 3);
    expect_pos(5, "down_79", 79, 1, 3);
    run(5);
    motor_cmd = 2'b00;
    expect_pos(1, "stop_cmd", 79, 0, 0);
    run(1);

    // Door opens while moving up.
    do_reset("reset_clr_ote");
    motor_cmd = 2'b01;
    expect_pos(34, "at_30", 30, 1, 1);
    run(34);
    door_open = 5'b00010;
    expect_all(1, "door_stop", 30, 0, 0, 0, 0, 1, 0, 0);
    run(1);
    expect_pos(3, "door_hold", 30, 0, 0);
    run(3);
    door_open = 5'b00000;
    expect_pos(4, "door_closed_go", 30, 1, 1);
    expect_pos(5, "resume_31", 31, 1, 1);
    run(5);

    // Reversal while moving up, then an invalid command.
    do_reset("reset_clr_dme");
    motor_cmd = 2'b01;
    expect_pos(14, "at_10", 10, 1, 1);
    run(14);
    motor_cmd = 2'b11;
    expect_pos(1, "rev_stop", 10, 0, 0);
    expect_pos(2, "rev_starting", 10, 0, 0);
    expect_pos(4, "rev_accel", 10, 0, 0);
    expect_pos(5, "rev_moving", 10, 1, 3);
    expect_pos(6, "rev_9", 9, 1, 3);
    run(6);
    motor_cmd = 2'b10;
    expect_all(1, "invalid", 9, 0, 0, 0, 0, 0, 0, 1);
    run(1);

    // Bottom overtravel, door-blocked start, then reset mid-move.
    do_reset("reset_clr_inv");
    motor_cmd = 2'b11;
    expect_all(1, "bottom_over", 0, 1, 1, 0, 0, 0, 1, 0);
    run(1);
    motor_cmd = 2'b01;
    door_open = 5'b00001;
    push(1, "door_blocks_start", 5, 1);
    expect_pos(1, "door_blocks_pos", 0, 0, 0);
    run(1);
    door_open = 5'b00000;
    expect_pos(51, "at_47", 47, 1, 1);
    run(51);
    do_reset("reset_mid_move");

    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
